// File: rtl/mega_jsoc_irqc_pkg.sv
// Shared constants and types for the mega_jsoc interrupt controller.
package mega_jsoc_irqc_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned MAX_IRQ       = 16;
    localparam int unsigned VEC_VALID_BIT = 15;

    localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd5;

    // VECTOR register layout as seen on the bus
    typedef struct packed {
        logic                             valid;
        logic [VEC_VALID_BIT-IDX_W-1:0]   rsvd;
        logic [IDX_W-1:0]                 index;
    } vector_t;

endpackage

// File: rtl/mega_jsoc_irq_ctrl_if.sv
// Avalon-MM register slave bus for the interrupt controller.
interface mega_jsoc_irq_ctrl_if;
    import mega_jsoc_irqc_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/mega_jsoc_irqc_prio_enc.sv
// Fixed-priority encoder: lowest-numbered set request wins.
module mega_jsoc_irqc_prio_enc
    import mega_jsoc_irqc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan upward and latch the first set bit only
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mega_jsoc_irq_ctrl.sv
// Interrupt controller with PENDING/MASK/ACTIVE/VECTOR/FORCE/CTRL registers.
// Build option: MEGA_JSOC_IRQC_EDGE_EN selects rising-edge capture of irq_in
// (with a per-source history register); otherwise sources are level-captured.
module mega_jsoc_irq_ctrl
    import mega_jsoc_irqc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mega_jsoc_irq_ctrl_if.slave   bus,
    input  logic [NUM_IRQ-1:0]    irq_in,
    output logic                  irq_out,
    output logic [IDX_W-1:0]      irq_index
);

    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata_irq;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               ctrl_en_q, ctrl_en_d;
    logic [NUM_IRQ-1:0] hw_set, w1c, force_set;
    logic [NUM_IRQ-1:0] active;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_index;
    logic               vec_valid_q;
    logic [DATA_W-1:0]  rdata_d, rdata_q;
    logic               unused_wdata;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wdata_irq = bus.writedata[NUM_IRQ-1:0];
    assign active    = pending_q & mask_q;
    // Write bits above the implemented sources are intentionally dropped
    assign unused_wdata = ^bus.writedata;

`ifdef MEGA_JSOC_IRQC_EDGE_EN
    logic [NUM_IRQ-1:0] hist_q;

    // Previous-cycle copy of irq_in for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist_q <= '0;
        else          hist_q <= irq_in;
    end

    assign hw_set = irq_in & ~hist_q;
`else
    assign hw_set = irq_in;
`endif

    // Register write decode and next-state; hardware set beats software clear
    always_comb begin
        w1c       = '0;
        force_set = '0;
        mask_d    = mask_q;
        ctrl_en_d = ctrl_en_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_PENDING: w1c       = wdata_irq;
                ADDR_MASK:    mask_d    = wdata_irq;
                ADDR_FORCE:   force_set = wdata_irq;
                ADDR_CTRL:    ctrl_en_d = bus.writedata[0];
                default:      ;
            endcase
        end
        pending_d = (pending_q & ~w1c) | hw_set | force_set;
    end

    mega_jsoc_irqc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req   (active),
        .valid (enc_valid),
        .index (enc_index)
    );

    // Read mux feeding the registered readdata
    always_comb begin
        vector_t vec;
        vec     = '{valid: vec_valid_q, rsvd: '0, index: irq_index};
        rdata_d = '0;
        case (bus.address)
            ADDR_PENDING: rdata_d = DATA_W'(pending_q);
            ADDR_MASK:    rdata_d = DATA_W'(mask_q);
            ADDR_ACTIVE:  rdata_d = DATA_W'(active);
            ADDR_VECTOR:  rdata_d = vec;
            ADDR_CTRL:    rdata_d = DATA_W'(ctrl_en_q);
            default:      rdata_d = '0;
        endcase
    end

    // Architectural registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            mask_q      <= '0;
            ctrl_en_q   <= 1'b0;
            rdata_q     <= '0;
            irq_out     <= 1'b0;
            irq_index   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            ctrl_en_q   <= ctrl_en_d;
            rdata_q     <= rdata_d;
            irq_out     <= (|active) & ctrl_en_q;
            irq_index   <= enc_index;
            vec_valid_q <= enc_valid;
        end
    end

    assign bus.readdata = rdata_q;

endmodule

// File: doc/mega_jsoc_irq_ctrl.md
MEGA_JSOC_IRQ_CTRL -- requirements
Module: mega_jsoc_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt sources, legal range 1..16.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  3  Avalon-MM register word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  16  write data.
REQ-008 readdata  output  16  registered read data.
REQ-009 irq_in  input  NUM_IRQ  interrupt requests from peripherals (e.g. the timer irq); synchronous to clk.
REQ-010 irq_out  output  1  combined, registered interrupt to the CPU.
REQ-011 irq_index  output  4  registered index of the highest-priority active source.

Function
REQ-012 Register map: 0 PENDING (read; write-1-to-clear), 1 MASK (read/write; 1 = enabled), 2 ACTIVE (read-only; PENDING & MASK), 3 VECTOR (read-only; bit15 = valid, bits 3:0 = index), 4 FORCE (write-only; write-1-to-set PENDING; reads 0), 5 CTRL (read/write; bit0 = global enable). Addresses 6 and 7 read 0 and ignore writes.
REQ-013 Write strobe is chipselect && ~write_n; writes take effect on the next rising edge.
REQ-014 readdata is registered every cycle from the address mux, independent of chipselect, giving 1-cycle read latency.
REQ-015 Bits at or above NUM_IRQ in PENDING, MASK and ACTIVE read 0 and ignore writes.
REQ-016 Priority is fixed: the lowest-numbered active bit wins.
REQ-017 VECTOR.valid and irq_index are registered from ACTIVE; irq_index = 0 when no bit is active.
REQ-018 irq_out is registered and equals (|ACTIVE) && CTRL[0], lagging PENDING/MASK/CTRL changes by one cycle.
REQ-019 Simultaneous hardware set and software W1C on the same bit: the set wins and the bit stays 1.
REQ-020 Simultaneous FORCE and PENDING writes in one cycle are impossible (single address); FORCE ORs with hardware sets.
REQ-021 MASK gates only ACTIVE and irq_out; masked sources still latch into PENDING.
REQ-022 CTRL[0]=0 holds irq_out low but leaves VECTOR and irq_index live for polling.

Reset
REQ-023 On reset_n low: PENDING=0, MASK=0, CTRL=0, readdata=0, irq_out=0, irq_index=0, and the edge history register (if present)=0.
REQ-024 Reset asserted mid-operation clears all state immediately; no pending interrupt survives reset.

Configuration
REQ-025 Macro MEGA_JSOC_IRQC_EDGE_EN defined: a PENDING bit sets on a rising edge of irq_in (current high, previous cycle low), detected with a per-bit history register; W1C clears the bit even while the source stays high.
REQ-026 Macro undefined: level mode; a PENDING bit sets every cycle irq_in is high, so W1C is ineffective while the source is asserted (per REQ-019); no history register is built.

Structure
REQ-027 Shared package mega_jsoc_irqc_pkg holds the register address constants, the 16-bit data width constant, the maximum NUM_IRQ (16) and the VECTOR.valid bit position.
REQ-028 The priority encoder is a separate sub-module, mega_jsoc_irqc_prio_enc (NUM_IRQ-bit one-hot-to-index plus valid); all other logic is in the top level.

Verification
REQ-029 Reset, then read addresses 0..7 -> readdata 0x0000 one cycle after each address; irq_out=0.
REQ-030 MASK=0x0001, CTRL=1, pulse irq_in[0] for 1 cycle (edge build) -> PENDING=0x0001; irq_out=1 one cycle after PENDING sets; VECTOR=0x8000; write PENDING=0x0001 -> irq_out=0 one cycle after the clear.
REQ-031 MASK=0x00FF, CTRL=1, FORCE=0x0028 -> ACTIVE=0x0028, VECTOR=0x8003; clear bit 3 -> VECTOR=0x8005.
REQ-032 irq_in[2] rising in the same cycle as a W1C of PENDING bit 2 -> PENDING bit 2 remains 1.
REQ-033 MASK=0, irq_in[1] pulsed -> PENDING=0x0002, ACTIVE=0, irq_out=0; then MASK=0x0002 -> irq_out=1 one cycle after the MASK write takes effect; CTRL=0 -> irq_out=0 while VECTOR=0x8001.
REQ-034 Level build: hold irq_in[4]=1, W1C bit 4 -> PENDING bit 4 stays 1; drop irq_in[4], W1C bit 4 -> PENDING=0. Assert reset_n low with PENDING nonzero -> all outputs 0 immediately.
